// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the core front end: the PC
//               source selector, the PC controller state encoding, the
//               default reset vector and an alignment helper.
// Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

  // Next-PC source selector. Encodings 6 and 7 are reserved and are treated
  // as SEQ by the consumers.
  typedef enum logic [2:0] {
    SEQ    = 3'd0,
    BRANCH = 3'd1,
    JAL    = 3'd2,
    JALR   = 3'd3,
    TRAP   = 3'd4,
    MRET   = 3'd5
  } pc_src_e;

  // PC controller sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2
  } pc_state_e;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  // True when an instruction address is not word aligned.
  function automatic logic addr_misaligned(input logic [31:0] a);
    return (a[1:0] != 2'b00);
  endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/pc_target_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_target_gen
// Description : Purely combinational next-PC target generator. Selects and
//               computes the target address for the captured PC source and
//               flags the sources whose target is subject to the alignment
//               check (taken BRANCH, JAL, JALR).
// Revision    : 1.0  initial release
// Ports       : i_pc          current program counter
//               i_sel         PC source (pc_src_e encoding, 6/7 act as SEQ)
//               i_take_branch branch-condition result
//               i_rs1, i_imm  JALR base register / sign-extended immediate
//               i_mtvec       trap vector
//               i_mepc        exception return PC
//               o_target      computed next PC
//               o_check_align target must be checked for misalignment
// ============================================================================
module pc_target_gen
  import core_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [2:0]  i_sel,
  input  logic        i_take_branch,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  output logic [31:0] o_target,
  output logic        o_check_align
);

  // All sums wrap modulo 2^32 by construction of the 32-bit result width.
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_imm;
  logic [31:0] w_rs1_imm;

  assign w_pc_plus4 = i_pc + 32'd4;
  assign w_pc_imm   = i_pc + i_imm;
  assign w_rs1_imm  = i_rs1 + i_imm;

  always_comb begin
    o_target      = w_pc_plus4;
    o_check_align = 1'b0;
    case (i_sel)
      BRANCH: begin
        if (i_take_branch) begin
          o_target      = w_pc_imm;
          o_check_align = 1'b1;
        end
      end
      JAL: begin
        o_target      = w_pc_imm;
        o_check_align = 1'b1;
      end
      JALR: begin
        o_target      = {w_rs1_imm[31:1], 1'b0};
        o_check_align = 1'b1;
      end
      TRAP:    o_target = {i_mtvec[31:2], 2'b00};
      MRET:    o_target = i_mepc;
      default: o_target = w_pc_plus4;  // SEQ and reserved encodings
    endcase
  end

endmodule : pc_target_gen
`default_nettype wire

// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_ctrl
// Description : Program-counter controller. Accepts one next-PC request at a
//               time (IDLE), computes the target into a register (CALC) and
//               commits it to the PC with a one-cycle done pulse (COMMIT).
//               A request accepted in cycle T gives done in T+2 and the new
//               PC from T+3.
// Revision    : 1.0  initial release
// Config      : PC_MISALIGN_TRAP_EN - when defined, a misaligned target of a
//               taken BRANCH, JAL or JALR is not loaded; misaligned pulses
//               with done and bad_target holds the offending address. When
//               undefined, misaligned/bad_target stay 0 and every target
//               loads unchecked.
// Ports       : clk, rst      clock, synchronous active-high reset
//               req_valid/req_ready  request handshake (ready only in IDLE)
//               req_sel       PC source (pc_src_e)
//               take_branch   branch condition
//               rs1, imm, mtvec, mepc  target operands
//               pc, pc_plus4  current PC and PC+4 (combinational)
//               done          commit pulse
//               misaligned, bad_target  misaligned-target report
// ============================================================================
module pc_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_sel,
  input  logic        take_branch,
  input  logic [31:0] rs1,
  input  logic [31:0] imm,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] bad_target
);

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic c_MISALIGN_TRAP_EN = 1'b1;
`else
  localparam logic c_MISALIGN_TRAP_EN = 1'b0;
`endif

  pc_state_e   r_state;
  pc_state_e   w_state_next;

  // Operands captured at acceptance; frozen until the request commits.
  logic [2:0]  r_sel;
  logic        r_take_branch;
  logic [31:0] r_rs1;
  logic [31:0] r_imm;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;

  logic [31:0] r_pc;
  logic [31:0] r_target;
  logic        r_mis;
  logic [31:0] r_bad;

  logic [31:0] w_target;
  logic        w_check_align;
  logic        w_fault;

  pc_target_gen u_target_gen (
    .i_pc          (r_pc),
    .i_sel         (r_sel),
    .i_take_branch (r_take_branch),
    .i_rs1         (r_rs1),
    .i_imm         (r_imm),
    .i_mtvec       (r_mtvec),
    .i_mepc        (r_mepc),
    .o_target      (w_target),
    .o_check_align (w_check_align)
  );

  // With the trap disabled this folds to 0, so the PC always loads and the
  // misaligned report registers never leave their reset value.
  assign w_fault = c_MISALIGN_TRAP_EN & w_check_align & addr_misaligned(w_target);

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_next = ST_CALC;
      end
      ST_CALC:   w_state_next = ST_COMMIT;
      ST_COMMIT: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_VEC;
      r_sel         <= 3'd0;
      r_take_branch <= 1'b0;
      r_rs1         <= 32'd0;
      r_imm         <= 32'd0;
      r_mtvec       <= 32'd0;
      r_mepc        <= 32'd0;
      r_target      <= 32'd0;
      r_mis         <= 1'b0;
      r_bad         <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && req_valid) begin
        r_sel         <= req_sel;
        r_take_branch <= take_branch;
        r_rs1         <= rs1;
        r_imm         <= imm;
        r_mtvec       <= mtvec;
        r_mepc        <= mepc;
      end
      if (r_state == ST_CALC) begin
        r_target <= w_target;
        r_mis    <= w_fault;
        // Loaded one cycle early so it is valid alongside the misaligned pulse.
        if (w_fault) r_bad <= w_target;
      end
      if (r_state == ST_COMMIT && !r_mis) begin
        r_pc <= r_target;
      end
    end
  end

  assign pc         = r_pc;
  assign pc_plus4   = r_pc + 32'd4;
  assign misaligned = (r_state == ST_COMMIT) & r_mis;
  assign bad_target = r_bad;

endmodule : pc_ctrl
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_ctrl
// Description : Self-checking bench for pc_ctrl. A request-level reference
//               model predicts ready/done/pc/pc_plus4/misaligned/bad_target
//               every cycle; directed sequences pin known results with
//               literal values, then randomized traffic with occasional
//               resets exercises the rest. Honours PC_MISALIGN_TRAP_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pc_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_sel;
  logic        take_branch;
  logic [31:0] rs1, imm, mtvec, mepc;
  logic [31:0] pc, pc_plus4, bad_target;
  logic        done, misaligned;

  pc_ctrl #(.RESET_VEC(RV)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sel     (req_sel),
    .take_branch (take_branch),
    .rs1         (rs1),
    .imm         (imm),
    .mtvec       (mtvec),
    .mepc        (mepc),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .done        (done),
    .misaligned  (misaligned),
    .bad_target  (bad_target)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one outstanding request, identified by the cycle it
  // was accepted in; it commits two cycles later.
  logic [31:0] m_pc     = RV;
  logic [31:0] m_bad    = 32'd0;
  logic [31:0] m_target = 32'd0;
  bit          m_pending = 1'b0;
  bit          m_mis     = 1'b0;
  int          m_acc     = 0;
  int          cyc       = 0;

  logic        s_mis;
  logic [31:0] s_bad;

  function automatic logic [31:0] ref_target(input logic [2:0] sel, input logic tb,
      input logic [31:0] cur, input logic [31:0] r1, input logic [31:0] im,
      input logic [31:0] tv, input logic [31:0] ep);
    logic [31:0] t;
    case (sel)
      3'd1:    t = tb ? cur + im : cur + 32'd4;
      3'd2:    t = cur + im;
      3'd3:    t = (r1 + im) & 32'hFFFF_FFFE;
      3'd4:    t = tv & 32'hFFFF_FFFC;
      3'd5:    t = ep;
      default: t = cur + 32'd4;
    endcase
    return t;
  endfunction

  function automatic bit ref_mis(input logic [2:0] sel, input logic tb,
      input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
    return (((sel == 3'd1) && tb) || sel == 3'd2 || sel == 3'd3) && (t[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update with the inputs present at this rising edge.
  task automatic model_edge();
    if (rst) begin
      m_pc      = RV;
      m_pending = 1'b0;
      m_bad     = 32'd0;
    end else if (!m_pending && req_valid) begin
      m_pending = 1'b1;
      m_acc     = cyc;
      m_target  = ref_target(req_sel, take_branch, m_pc, rs1, imm, mtvec, mepc);
      m_mis     = ref_mis(req_sel, take_branch, m_target);
    end else if (m_pending && cyc == m_acc + 2) begin
      if (!m_mis) m_pc = m_target;
      m_pending = 1'b0;
    end
    cyc++;
  endtask

  task automatic compare();
    bit e_done;
    e_done = m_pending && (cyc == m_acc + 2);
    if (e_done && m_mis) m_bad = m_target;
    chk32("req_ready",  {31'd0, req_ready},  {31'd0, !m_pending});
    chk32("done",       {31'd0, done},       {31'd0, e_done});
    chk32("pc",         pc,                  m_pc);
    chk32("pc_plus4",   pc_plus4,            m_pc + 32'd4);
    chk32("misaligned", {31'd0, misaligned}, {31'd0, e_done && m_mis});
    chk32("bad_target", bad_target,          m_bad);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  // Issue one request in cycle T and run to T+3. With hold set, req_valid
  // stays high with scrambled operands during CALC and COMMIT.
  task automatic run_req(input logic [2:0] sel, input logic tb, input logic [31:0] r1,
      input logic [31:0] im, input logic [31:0] tv, input logic [31:0] ep, input bit hold);
    req_sel = sel; take_branch = tb; rs1 = r1; imm = im; mtvec = tv; mepc = ep;
    req_valid = 1'b1;
    step();                                  // in T+1
    chk32("ready_in_calc", {31'd0, req_ready}, 32'd0);
    if (hold) begin
      req_valid = 1'b1; req_sel = 3'($urandom_range(0, 7)); take_branch = ~tb;
      rs1 = $urandom; imm = $urandom; mtvec = $urandom; mepc = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    step();                                  // in T+2
    chk32("done_at_T2", {31'd0, done}, 32'd1);
    chk32("ready_in_commit", {31'd0, req_ready}, 32'd0);
    s_mis = misaligned;
    s_bad = bad_target;
    req_valid = 1'b0;
    step();                                  // in T+3
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_sel = 3'd0; take_branch = 1'b0;
    rs1 = 32'd0; imm = 32'd0; mtvec = 32'd0; mepc = 32'd0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    step();
    chk32("reset_pc",    pc,                  32'h0);
    chk32("reset_ready", {31'd0, req_ready},  32'd1);
    chk32("reset_done",  {31'd0, done},       32'd0);
    chk32("reset_mis",   {31'd0, misaligned}, 32'd0);
    chk32("reset_bad",   bad_target,          32'd0);

    run_req(3'd0, 1'b0, 0, 0, 0, 0, 1'b0);
    chk32("seq_pc", pc, 32'h4);

    run_req(3'd5, 1'b0, 0, 0, 0, 32'h100, 1'b0);
    run_req(3'd1, 1'b1, 0, 32'hFFFF_FFF0, 0, 0, 1'b0);
    chk32("branch_taken_pc", pc, 32'hF0);
    run_req(3'd5, 1'b0, 0, 0, 0, 32'h100, 1'b0);
    run_req(3'd1, 1'b0, 0, 32'hFFFF_FFF0, 0, 0, 1'b0);
    chk32("branch_not_taken_pc", pc, 32'h104);

    run_req(3'd3, 1'b0, 32'h2001, 32'h4, 0, 0, 1'b1);
    chk32("jalr_pc_with_busy_valid", pc, 32'h2004);
    step();
    chk32("no_second_accept_ready", {31'd0, req_ready}, 32'd1);
    run_req(3'd4, 1'b0, 0, 0, 32'h8000_0003, 0, 1'b0);
    chk32("trap_pc", pc, 32'h8000_0000);

    run_req(3'd5, 1'b0, 0, 0, 0, 32'h200, 1'b0);
    run_req(3'd2, 1'b0, 0, 32'h6, 0, 0, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
    chk32("jal_mis_flag", {31'd0, s_mis}, 32'd1);
    chk32("jal_mis_bad",  s_bad,          32'h206);
    chk32("jal_mis_pc",   pc,             32'h200);
`else
    chk32("jal_mis_flag", {31'd0, s_mis}, 32'd0);
    chk32("jal_pc",       pc,             32'h206);
`endif

    run_req(3'd5, 1'b0, 0, 0, 0, 32'hFFFF_FFFC, 1'b0);
    run_req(3'd0, 1'b0, 0, 0, 0, 0, 1'b0);
    chk32("wrap_pc", pc, 32'h0);
    run_req(3'd6, 1'b1, 32'h55, 32'h40, 32'h1000, 32'h2000, 1'b0);
    chk32("reserved6_pc", pc, 32'h4);
    run_req(3'd7, 1'b1, 32'h55, 32'h40, 32'h1000, 32'h2000, 1'b0);
    chk32("reserved7_pc", pc, 32'h8);

    // Reset arriving while a JAL is in CALC.
    run_req(3'd5, 1'b0, 0, 0, 0, 32'h300, 1'b0);
    req_sel = 3'd2; imm = 32'h8; req_valid = 1'b1;
    step();                                  // JAL now in CALC
    req_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk32("rst_calc_pc",   pc,             RV);
    chk32("rst_calc_done", {31'd0, done},  32'd0);
    step();
    chk32("rst_calc_done_later", {31'd0, done}, 32'd0);
    step();
    chk32("rst_calc_pc_later", pc, RV);

    // Randomized traffic, including reset overlapping a request (req_valid
    // and rst together must not accept).
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      req_valid   = 1'($urandom_range(0, 1));
      req_sel     = 3'($urandom_range(0, 7));
      take_branch = 1'($urandom_range(0, 1));
      rs1         = $urandom;
      imm         = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      mtvec       = $urandom;
      mepc        = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      step();
    end
    rst = 1'b0; req_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pc_ctrl
`default_nettype wire

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  a next-PC request is offered.
REQ-005 SHALL have port req_ready  output  1  the block accepts a request this cycle.
REQ-006 SHALL have port req_sel  input  3  PC source, type pc_src_e: SEQ=0, BRANCH=1, JAL=2, JALR=3, TRAP=4, MRET=5.
REQ-007 SHALL have port take_branch  input  1  branch-condition result for the conditional branch.
REQ-008 SHALL have ports rs1, imm, mtvec, mepc  input  32 each  operand, sign-extended immediate, trap vector and exception PC.
REQ-009 SHALL have port pc  output  32  the current program counter.
REQ-010 SHALL have port pc_plus4  output  32  pc+4, combinational, for link-register writeback.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the request commits.
REQ-012 SHALL have ports misaligned  output  1  and bad_target  output  32  misaligned-target pulse and the offending address.

Function
REQ-013 SHALL implement FSM states IDLE, CALC and COMMIT; req_ready SHALL be 1 only in IDLE.
REQ-014 IDLE: when req_valid=1, SHALL register req_sel, take_branch, rs1, imm, mtvec and mepc, and go to CALC.
REQ-015 CALC: SHALL compute the target into a register and go to COMMIT; COMMIT: SHALL pulse done, update pc, and go to IDLE.
REQ-016 Latency: for a request accepted in cycle T, done SHALL be 1 in T+2 and pc SHALL show the new value from T+3.
REQ-017 Targets SHALL be:
- SEQ: pc+4.
- BRANCH: pc+imm if take_branch, else pc+4.
- JAL: pc+imm.
- JALR: (rs1+imm) with bit 0 cleared.
- TRAP: {mtvec[31:2],2'b00}.
- MRET: mepc.
REQ-018 All additions SHALL be modulo 2^32, with silent wrap-around (0xFFFF_FFFC+4 = 0).
REQ-019 Reserved req_sel values 6 and 7 SHALL behave as SEQ.
REQ-020 req_valid SHALL be ignored outside IDLE, and captured operands SHALL NOT change during CALC or COMMIT.
REQ-021 take_branch SHALL be sampled only at acceptance, with no effect for sources other than BRANCH.

Reset
REQ-022 On rst=1 at a clock edge: pc=RESET_VEC, FSM=IDLE, done=0, misaligned=0, bad_target=0; any in-flight request SHALL be discarded without updating pc.
REQ-023 rst SHALL take priority over a simultaneous req_valid.

Configuration
REQ-024 With macro PC_MISALIGN_TRAP_EN defined: for taken BRANCH, JAL or JALR whose target[1:0] != 0, COMMIT SHALL leave pc unchanged, pulse misaligned with done, and set bad_target = target.
REQ-025 Under PC_MISALIGN_TRAP_EN, SEQ, TRAP and MRET SHALL never raise misaligned.
REQ-026 Without PC_MISALIGN_TRAP_EN: misaligned and bad_target SHALL be constant 0 and pc SHALL load the target unchecked.

Structure
REQ-027 The enum pc_src_e and the default reset vector SHALL live in shared package core_pkg.
REQ-028 Target arithmetic SHALL be a combinational sub-module pc_target_gen; the FSM and registers SHALL stay in pc_ctrl.

Verification
REQ-029 Reset, then SEQ request at pc=0 -> done in T+2, pc=0x4 at T+3, req_ready=0 in T+1 and T+2.
REQ-030 pc=0x100, BRANCH, imm=0xFFFF_FFF0: take_branch=1 -> pc=0xF0; take_branch=0 -> pc=0x104.
REQ-031 JALR rs1=0x2001, imm=0x4 -> pc=0x2004; TRAP mtvec=0x8000_0003 -> pc=0x8000_0000.
REQ-032 PC_MISALIGN_TRAP_EN: pc=0x200, JAL imm=0x6 -> misaligned=1, bad_target=0x206, pc stays 0x200; without macro -> pc=0x206.
REQ-033 rst asserted in CALC of a JAL -> pc=RESET_VEC next cycle, no done pulse; req_valid toggled in CALC/COMMIT -> no second accept.
